// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter
// Shares one AES Cipher instance between two plaintext requesters.
// Requests are granted round-robin, the granted block is captured and held
// on the core input, the core is restarted and then enabled for a fixed
// number of cycles (the core has no completion flag), and the ciphertext is
// returned together with the requester index over a valid/ready port.

module aes_core_arbiter #(
    parameter int CORE_LAT = 12,
    localparam int CNT_W = $clog2(CORE_LAT + 1)
) (
    input  logic         clks,
    input  logic         reset,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_data,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_data,

    output logic         core_reset,
    output logic         core_enable,
    output logic [127:0] core_plainText,
    input  logic [127:0] core_encryptedText,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_data,

    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        RESP   = 2'd3
    } arbState_t;

    arbState_t          state_r;
    arbState_t          nextState_s;

    logic               lastGrant_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [127:0]       ptReg_r;
    logic               idReg_r;

    logic               rspValid_r;
    logic               rspId_r;
    logic [127:0]       rspData_r;

    logic               grant_s;
    logic               req0Ready_s;
    logic               req1Ready_s;
    logic               cntZero_s;
    logic               rspHandshake_s;

    logic               coreReset_s;
    logic               coreEnable_s;
    logic               busy_s;

    assign cntZero_s      = (cnt_r == {CNT_W{1'b0}});
    assign rspHandshake_s = rspValid_r & rsp_ready;

    // Round-robin pick: a lone requester always wins, a tie goes to the
    // requester that was not served last.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~lastGrant_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Accept strobes: only in IDLE, only for the granted requester, never
    // while reset is applied (a handshake then would be silently lost).
    always_comb begin
        req0Ready_s = 1'b0;
        req1Ready_s = 1'b0;
        if (!reset && (state_r == IDLE)) begin
            req0Ready_s = req0_valid & ~grant_s;
            req1Ready_s = req1_valid &  grant_s;
        end else begin
            req0Ready_s = 1'b0;
            req1Ready_s = 1'b0;
        end
    end

    // Next-state logic of the job sequencer.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (req0Ready_s || req1Ready_s) begin
                    nextState_s = LAUNCH;
                end else begin
                    nextState_s = IDLE;
                end
            end
            LAUNCH: begin
                nextState_s = RUN;
            end
            RUN: begin
                if (cntZero_s) begin
                    nextState_s = RESP;
                end else begin
                    nextState_s = RUN;
                end
            end
            RESP: begin
                if (rspHandshake_s) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = RESP;
                end
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // State register; reset abandons any job in flight.
    always_ff @(posedge clks) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Job datapath: capture the granted block, time the core, capture the
    // ciphertext on the last enabled cycle and release it on the handshake.
    always_ff @(posedge clks) begin
        if (reset) begin
            lastGrant_r <= 1'b1;
            cnt_r       <= {CNT_W{1'b0}};
            ptReg_r     <= 128'd0;
            idReg_r     <= 1'b0;
            rspValid_r  <= 1'b0;
            rspId_r     <= 1'b0;
            rspData_r   <= 128'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req0Ready_s) begin
                        ptReg_r <= req0_data;
                        idReg_r <= 1'b0;
                    end else if (req1Ready_s) begin
                        ptReg_r <= req1_data;
                        idReg_r <= 1'b1;
                    end else begin
                        ptReg_r <= ptReg_r;
                        idReg_r <= idReg_r;
                    end
                end
                LAUNCH: begin
                    cnt_r <= CNT_W'(CORE_LAT - 1);
                end
                RUN: begin
                    if (cntZero_s) begin
                        rspData_r  <= core_encryptedText;
                        rspId_r    <= idReg_r;
                        rspValid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rspHandshake_s) begin
                        rspValid_r  <= 1'b0;
                        lastGrant_r <= idReg_r;
                    end else begin
                        rspValid_r  <= rspValid_r;
                        lastGrant_r <= lastGrant_r;
                    end
                end
                default: begin
                    rspValid_r <= 1'b0;
                end
            endcase
        end
    end

    // Core control decoded from the registered state; the core is held in
    // restart for as long as this block is in reset.
    always_comb begin
        coreReset_s  = 1'b0;
        coreEnable_s = 1'b0;
        busy_s       = 1'b0;
        if (reset) begin
            coreReset_s  = 1'b1;
            coreEnable_s = 1'b0;
            busy_s       = 1'b0;
        end else begin
            coreReset_s  = (state_r == LAUNCH);
            coreEnable_s = (state_r == RUN);
            busy_s       = (state_r != IDLE);
        end
    end

    assign req0_ready     = req0Ready_s;
    assign req1_ready     = req1Ready_s;
    assign core_reset     = coreReset_s;
    assign core_enable    = coreEnable_s;
    assign core_plainText = ptReg_r;
    assign rsp_valid      = rspValid_r;
    assign rsp_id         = rspId_r;
    assign rsp_data       = rspData_r;
    assign busy           = busy_s;

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one AES encryption core (Cipher, Nk=4, round keys supplied externally) between two independent plaintext requesters.
- Arbitrates round-robin and captures the granted block.
- Sequences the core: restart pulse, then enable for a fixed latency. Captures the ciphertext and returns it with a requester ID over a valid/ready response port.
- Sits between the bus-side request queues and the Cipher instance. Cipher has no done flag, so this block owns all timing.

Parameters:
- CORE_LAT, 12, number of clks core_enable is held high before core_encryptedText is final (must be >= 1).
- CNT_W, $clog2(CORE_LAT+1), width of the latency counter (derived, not overridden).

Ports:
- clks  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a block
- req0_ready  out  1  requester 0 block accepted this cycle when high with req0_valid
- req0_data  in  128  requester 0 plaintext, bit 0 = MSB
- req1_valid  in  1  requester 1 has a block
- req1_ready  out  1  requester 1 accept
- req1_data  in  128  requester 1 plaintext
- core_reset  out  1  synchronous restart to Cipher
- core_enable  out  1  enable to Cipher
- core_plainText  out  128  plaintext driven to Cipher
- core_encryptedText  in  128  ciphertext from Cipher
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index of response
- rsp_data  out  128  ciphertext
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins first), cnt=0, pt_reg=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, core_enable=0, busy=0, req*_ready=0.
  - core_reset=1 while reset is high.
- States IDLE, LAUNCH, RUN, RESP.
- IDLE:
  - grant = the sole valid requester. If both are valid, grant = !last_grant.
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid, combinational from registered state. At most one ready per cycle.
  - On handshake: pt_reg<=reqN_data, id_reg<=N, next state LAUNCH. With no valid requester, stay in IDLE.
- LAUNCH (1 cycle):
  - core_reset=1, core_enable=0, core_plainText=pt_reg.
  - cnt<=CORE_LAT-1, next state RUN.
- RUN:
  - core_reset=0, core_enable=1, core_plainText=pt_reg (held stable for the whole job).
  - cnt decrements each clk.
  - On the cycle cnt==0: rsp_data<=core_encryptedText, rsp_id<=id_reg, rsp_valid<=1, next state RESP.
  - RUN therefore lasts exactly CORE_LAT cycles.
- RESP:
  - core_enable=0. rsp_valid, rsp_data and rsp_id are held stable until rsp_valid && rsp_ready.
  - On that handshake: rsp_valid<=0, last_grant<=id_reg, next state IDLE.
  - rsp_ready held low stalls indefinitely. No new request is accepted while stalled.
- Latency: request handshake at cycle T gives rsp_valid high at T+CORE_LAT+2. Minimum job period is CORE_LAT+3 clks, with rsp_ready tied high.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- reqN_valid dropping before its handshake cancels that request without side effects. Requesters hold data stable while valid.
- Reset in any state:
  - Next cycle is IDLE with reset values.
  - An in-flight job is discarded and no response is issued.
  - core_reset stays high during reset.
- Simultaneous rsp handshake and new reqN_valid: the new request is not accepted in the same cycle. It is granted in the following IDLE cycle.
- core_encryptedText is ignored outside the RUN cnt==0 cycle.

Test Plan:
- Single request, behavioural core model with CORE_LAT=12, req0_data=00112233445566778899aabbccddeeff, model returns 69c4e0d86a7b0430d8cdb78070b4c55a at cnt==0 -> rsp_valid exactly 14 clks after the handshake, rsp_id=0, rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a, busy high from the cycle after the handshake through the response handshake.
- Both requesters valid continuously, rsp_ready=1, 6 jobs -> rsp_id sequence 0,1,0,1,0,1. Each req*_ready is a single-cycle pulse, never both high together.
- rsp_ready held low for 20 clks in RESP with req1_valid=1 -> rsp_valid, rsp_data and rsp_id stable, req1_ready stays 0. After rsp_ready=1, req1 is granted the next cycle.
- Reset asserted mid-RUN (cnt=5) -> next cycle state IDLE, rsp_valid=0, core_enable=0, core_reset=1. After reset release with both requesters valid, requester 0 is granted first.
- Integration with real Cipher (Nk=4, FIPS-197 key 000102...0f expansion, CORE_LAT tuned to the core) -> req1_data=00112233445566778899aabbccddeeff yields rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id=1.
- req0_valid pulsed for 1 cycle while a req1 job is in RUN -> req0 is never accepted and no spurious response appears.
